// File: rtl/axi_rd_fetch_master_if.sv
// AR/R read bus between the fetch master and the weight memory model.
// Master drives the burst request, slave returns one data beat per cycle.
interface axi_rd_fetch_master_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0] araddr;
  logic          arvalid;
  logic [3:0]    arburst;
  logic          arready;
  logic [DW-1:0] rdata;
  logic          rvalid;

  modport master (
    output araddr, arvalid, arburst,
    input  arready, rdata, rvalid
  );

  modport slave (
    input  araddr, arvalid, arburst,
    output arready, rdata, rvalid
  );
endinterface

// File: rtl/axi_rd_fetch_master.sv
// Weight fetch read initiator: splits one request into power-of-two
// bursts on the AR/R bus and streams beats into the weight buffer.
module axi_rd_fetch_master #(
  parameter int DW             = 32,
  parameter int AW             = 32,
  parameter int CNT_W          = 16,
  parameter int MAX_BURST_LOG2 = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [AW-1:0]          req_addr,
  input  logic [CNT_W-1:0]       req_len,
  output logic                   busy,
  output logic                   done,
  output logic                   protocol_err,
  axi_rd_fetch_master_if.master  bus,
  output logic                   wb_wr_en,
  output logic [CNT_W-1:0]       wb_wr_addr,
  output logic [DW-1:0]          wb_wr_data
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    FIN
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [AW-1:0]    cur_addr;
  logic [CNT_W-1:0] remain;
  logic [CNT_W-1:0] wr_idx;
  logic [CNT_W-1:0] beat_cnt;
  logic [3:0]       burst_log2;
  logic [3:0]       burst_q;
  logic             accept;
  logic             ar_fire;
  logic             beat_ok;
  logic             burst_end;

  assign accept    = (state == IDLE) && req_valid;
  assign ar_fire   = (state == ADDR) && bus.arready;
  assign beat_ok   = (state == DATA) && (beat_cnt != '0)
                   && bus.rvalid;
  assign burst_end = (state == DATA) && (beat_cnt == '0);

  assign bus.araddr  = cur_addr;
  assign bus.arburst = burst_log2;

  // Largest power-of-two burst not exceeding the remaining words
  always_comb begin
    burst_log2 = '0;
    for (int k = 0; k <= MAX_BURST_LOG2; k++) begin
      if (32'(remain) >= (32'd1 << k)) begin
        burst_log2 = 4'(k);
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state and handshake/status outputs
  always_comb begin
    state_nx    = state;
    req_ready   = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    bus.arvalid = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_nx = (req_len == '0) ? FIN : ADDR;
        end
      end
      ADDR: begin
        busy        = 1'b1;
        bus.arvalid = 1'b1;
        if (bus.arready) begin
          state_nx = DATA;
        end
      end
      DATA: begin
        busy = 1'b1;
        if (beat_cnt == '0) begin
          state_nx = (remain == '0) ? FIN : ADDR;
        end
      end
      FIN: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Address/count bookkeeping and registered buffer write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_addr     <= '0;
      remain       <= '0;
      wr_idx       <= '0;
      beat_cnt     <= '0;
      burst_q      <= '0;
      wb_wr_en     <= 1'b0;
      wb_wr_addr   <= '0;
      wb_wr_data   <= '0;
      protocol_err <= 1'b0;
    end else begin
      wb_wr_en     <= beat_ok;
      protocol_err <= bus.rvalid && !beat_ok;
      if (accept) begin
        cur_addr <= req_addr;
        remain   <= req_len;
        wr_idx   <= '0;
      end
      if (ar_fire) begin
        beat_cnt <= CNT_W'(1) << burst_log2;
        burst_q  <= burst_log2;
      end
      if (beat_ok) begin
        wb_wr_data <= bus.rdata;
        wb_wr_addr <= wr_idx;
        wr_idx     <= wr_idx + 1'b1;
        remain     <= remain - 1'b1;
        beat_cnt   <= beat_cnt - 1'b1;
      end
      if (burst_end) begin
        cur_addr <= cur_addr + (AW'(1) << burst_q);
      end
    end
  end

endmodule

// File: tb/tb_axi_rd_fetch_master.sv
// Directed bench for axi_rd_fetch_master: bursts, stalls, reset,
// zero-length and stray-beat cases.
module tb_axi_rd_fetch_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [15:0] req_len;
  logic        busy;
  logic        done;
  logic        protocol_err;
  logic        wb_wr_en;
  logic [15:0] wb_wr_addr;
  logic [31:0] wb_wr_data;

  axi_rd_fetch_master_if #(.AW(32), .DW(32)) bus ();

  axi_rd_fetch_master #(
    .DW(32), .AW(32), .CNT_W(16), .MAX_BURST_LOG2(3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_len      (req_len),
    .busy         (busy),
    .done         (done),
    .protocol_err (protocol_err),
    .bus          (bus),
    .wb_wr_en     (wb_wr_en),
    .wb_wr_addr   (wb_wr_addr),
    .wb_wr_data   (wb_wr_data)
  );

  always #5 clk = ~clk;

  int          nvec = 0;
  int          nerr = 0;
  int          wn = 0;
  logic [15:0] la [256];
  logic [31:0] ld [256];

  // Log every buffer write, sampled mid-cycle
  always @(negedge clk) begin
    if (wb_wr_en && wn < 256) begin
      la[wn] = wb_wr_addr;
      ld[wn] = wb_wr_data;
      wn++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [31:0] a, input logic [15:0] l);
    req_valid = 1'b1;
    req_addr  = a;
    req_len   = l;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic serve(input int hold, input logic [31:0] a,
                       input logic [3:0] b, input int nb);
    int k;
    k = 0;
    @(negedge clk);
    while (!bus.arvalid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("arvalid_up", bus.arvalid, 1);
    for (int i = 0; i < hold; i++) begin
      chk("hold_arvalid", bus.arvalid, 1);
      chk("hold_araddr", bus.araddr, a);
      chk("hold_arburst", bus.arburst, b);
      @(negedge clk);
    end
    bus.arready = 1'b1;
    chk("araddr", bus.araddr, a);
    chk("arburst", bus.arburst, b);
    @(posedge clk); #1;
    bus.arready = 1'b0;
    chk("arvalid_drop", bus.arvalid, 0);
    for (int i = 0; i < nb; i++) begin
      bus.rvalid = 1'b1;
      bus.rdata  = a + 32'(i);
      @(posedge clk); #1;
    end
    bus.rvalid = 1'b0;
  endtask

  task automatic fin_chk();
    chk("done_early", done, 0);
    @(posedge clk); #1;
    chk("done_pulse", done, 1);
    chk("busy_at_done", busy, 0);
    @(posedge clk); #1;
    chk("done_clear", done, 0);
    chk("ready_back", req_ready, 1);
  endtask

  task automatic wchk(input int base, input int n,
                      input logic [31:0] dbase);
    chk("write_count", 64'(wn - base), 64'(n));
    for (int i = 0; i < n && base + i < 256; i++) begin
      chk("wr_addr", la[base+i], 64'(i));
      chk("wr_data", ld[base+i], dbase + 32'(i));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    rst         = 1'b1;
    req_valid   = 1'b0;
    req_addr    = '0;
    req_len     = '0;
    bus.arready = 1'b0;
    bus.rvalid  = 1'b0;
    bus.rdata   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_arvalid", bus.arvalid, 0);
    chk("rst_araddr", bus.araddr, 0);
    chk("rst_arburst", bus.arburst, 0);
    chk("rst_wr_en", wb_wr_en, 0);
    chk("rst_wr_addr", wb_wr_addr, 0);
    chk("rst_wr_data", wb_wr_data, 0);
    chk("rst_perr", protocol_err, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // T1: single 8-beat burst
    base = wn;
    req(32'h10, 16'd8);
    chk("t1_busy", busy, 1);
    serve(0, 32'h10, 4'd3, 8);
    fin_chk();
    wchk(base, 8, 32'h10);

    // T2: 13 words as 8+4+1, arready withheld between bursts
    base = wn;
    req(32'h0, 16'd13);
    serve(2, 32'h0, 4'd3, 8);
    chk("t2_busy_mid", busy, 1);
    serve(1, 32'h8, 4'd2, 4);
    serve(0, 32'hC, 4'd0, 1);
    fin_chk();
    wchk(base, 13, 32'h0);

    // T3: zero length
    base = wn;
    req(32'h55, 16'd0);
    chk("t3_done", done, 1);
    chk("t3_arvalid", bus.arvalid, 0);
    @(posedge clk); #1;
    chk("t3_done_clear", done, 0);
    chk("t3_no_writes", 64'(wn - base), 0);

    // T4: arready stalled five cycles
    base = wn;
    req(32'h20, 16'd4);
    serve(5, 32'h20, 4'd2, 4);
    fin_chk();
    wchk(base, 4, 32'h20);

    // T5: reset in the middle of a burst, then a clean fetch
    req(32'h80, 16'd8);
    serve(0, 32'h80, 4'd3, 3);
    bus.rvalid = 1'b1;
    #1 rst = 1'b1;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_ready", req_ready, 1);
    chk("t5_done", done, 0);
    chk("t5_wr_en", wb_wr_en, 0);
    chk("t5_wr_addr", wb_wr_addr, 0);
    chk("t5_wr_data", wb_wr_data, 0);
    chk("t5_araddr", bus.araddr, 0);
    chk("t5_arburst", bus.arburst, 0);
    bus.rvalid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    base = wn;
    req(32'h40, 16'd4);
    serve(0, 32'h40, 4'd2, 4);
    fin_chk();
    wchk(base, 4, 32'h40);

    // T6: stray beat while idle
    base = wn;
    bus.rvalid = 1'b1;
    bus.rdata  = 32'hDEAD;
    @(posedge clk); #1;
    bus.rvalid = 1'b0;
    chk("t6_perr", protocol_err, 1);
    chk("t6_wr_en", wb_wr_en, 0);
    chk("t6_ready", req_ready, 1);
    chk("t6_busy", busy, 0);
    @(posedge clk); #1;
    chk("t6_perr_clear", protocol_err, 0);
    chk("t6_no_writes", 64'(wn - base), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
